// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 memory bus arbiter.
package c64_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;

    localparam logic SLOT_VIC = 1'b0;
    localparam logic SLOT_CPU = 1'b1;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        WARN    = 2'd1,
        VIC_OWN = 2'd2
    } state_t;

endpackage

// File: rtl/c64_bus_arbiter.sv
// Time-slices one synchronous memory between the 6502 and the VIC-II,
// running the BA/AEC cycle-stealing handshake and steering read data back.
module c64_bus_arbiter
    import c64_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned BA_WARN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_do,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_di,
    input  logic [ADDR_W-1:0] vic_addr,
    input  logic              vic_ba_req,
    output logic [DATA_W-1:0] vic_di,
    output logic              vic_di_valid,
    output logic              phi2,
    output logic              ba,
    output logic              aec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (BA_WARN < 1) ? 1 : $clog2(BA_WARN + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BA_WARN);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             vic_pend;
    logic             cpu_pend;
    logic             cpu_slot;
    logic             cpu_owner;
    logic             vic_sample_edge;

    // Bus mux and grant decode; depends only on registered state and requester inputs.
    always_comb begin
        cpu_slot        = (phi2 == SLOT_CPU);
        vic_sample_edge = (phi2 == SLOT_VIC);
        cpu_owner       = (state != VIC_OWN);
        cpu_rdy         = cpu_slot && ((state == CPU_OWN) || ((state == WARN) && cpu_we));
        mem_addr        = vic_addr;
        mem_wdata       = '0;
        if (cpu_slot && cpu_owner) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_do;
        end
        mem_we = cpu_we && cpu_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phi2         <= SLOT_VIC;
            ba           <= 1'b1;
            aec          <= 1'b1;
            vic_di       <= '0;
            vic_di_valid <= 1'b0;
            cpu_di       <= '0;
            vic_pend     <= 1'b0;
            cpu_pend     <= 1'b0;
            state        <= CPU_OWN;
            counter      <= '0;
        end else begin
            phi2         <= ~phi2;
            vic_di_valid <= vic_pend;
            if (vic_pend) vic_di <= mem_rdata;
            if (cpu_pend) cpu_di <= mem_rdata;
            // Tag which requester the data arriving next clk belongs to.
            vic_pend <= !(cpu_slot && cpu_owner);
            cpu_pend <= cpu_rdy && !cpu_we;

            if (vic_sample_edge) begin
                case (state)
                    CPU_OWN: if (vic_ba_req) begin
                        state   <= WARN;
                        ba      <= 1'b0;
                        counter <= CNT_INIT;
                    end
                    WARN: if (!vic_ba_req) begin
                        state   <= CPU_OWN;
                        ba      <= 1'b1;
                        counter <= '0;
                    end
                    VIC_OWN: if (!vic_ba_req) begin
                        state <= CPU_OWN;
                        ba    <= 1'b1;
                        aec   <= 1'b1;
                    end
                    default: state <= CPU_OWN;
                endcase
            end else if (state == WARN) begin
                // Every warning CPU slot counts, granted write or stalled read.
                if (counter <= CNT_W'(1)) begin
                    counter <= '0;
                    state   <= VIC_OWN;
                    aec     <= 1'b0;
                end else begin
                    counter <= counter - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Randomized bench for c64_bus_arbiter against a slot-level reference model.
module tb_c64_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int         BW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] cpu_addr, vic_addr, mem_addr;
    logic [DW-1:0] cpu_do, cpu_di, vic_di, mem_wdata, mem_rdata;
    logic          cpu_we, cpu_rdy, vic_ba_req, vic_di_valid, phi2, ba, aec, mem_we;

    c64_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BA_WARN(BW)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
        .vic_addr(vic_addr), .vic_ba_req(vic_ba_req),
        .vic_di(vic_di), .vic_di_valid(vic_di_valid),
        .phi2(phi2), .ba(ba), .aec(aec),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int a);
        if (a == 32'hE000) return 8'hA9;
        return 8'((a * 37) ^ (a >> 8));
    endfunction

    // Synchronous memory: data for an address appears the clk after it.
    logic [7:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference model: memory image, bus-ownership view and read-return pipeline.
    logic [7:0] ref_mem [0:65535];
    int         cyc;
    bit         ba_low, stolen;
    int         left;
    bit         fd1, fd2, cd1, cd2;
    logic [7:0] vd1, vd2, cv1, cv2, exp_vic_di, exp_cpu_di;

    logic [15:0] rq_addr;
    logic [7:0]  rq_do;
    logic        rq_we;
    bit          rq_new;
    int          req_left;
    logic        req_val;

    task automatic model_reset();
        cyc = 0; ba_low = 0; stolen = 0; left = 0;
        fd1 = 0; fd2 = 0; cd1 = 0; cd2 = 0;
        vd1 = '0; vd2 = '0; cv1 = '0; cv2 = '0;
        exp_vic_di = '0; exp_cpu_di = '0;
    endtask

    task automatic run_cycle(input bit force_req);
        bit slot_cpu, drives, grant;
        if (rq_new) begin
            rq_addr = 16'($urandom);
            rq_we   = ($urandom_range(0, 2) == 0);
            rq_do   = 8'($urandom);
            rq_new  = 0;
        end
        vic_addr = 16'($urandom);
        slot_cpu = ((cyc % 2) == 1);
        if (!slot_cpu) begin
            if (req_left == 0) begin
                req_val  = 1'($urandom_range(0, 1));
                req_left = int'($urandom_range(1, 6));
            end
            req_left--;
            if (force_req) req_val = 1'b1;
        end
        vic_ba_req = req_val;
        cpu_addr = rq_addr; cpu_we = rq_we; cpu_do = rq_do;

        drives = slot_cpu && !stolen;
        grant  = drives && (!ba_low || rq_we);
        if (fd2) exp_vic_di = vd2;
        if (cd2) exp_cpu_di = cv2;

        @(negedge clk);
        check("phi2", 32'(phi2), 32'(slot_cpu));
        check("cpu_rdy", 32'(cpu_rdy), 32'(grant));
        check("mem_addr", 32'(mem_addr), 32'(drives ? rq_addr : vic_addr));
        check("mem_we", 32'(mem_we), 32'(grant && rq_we));
        if (drives) check("mem_wdata", 32'(mem_wdata), 32'(rq_do));
        check("ba", 32'(ba), 32'(!ba_low));
        check("aec", 32'(aec), 32'(!stolen));
        check("vic_di_valid", 32'(vic_di_valid), 32'(fd2));
        check("vic_di", 32'(vic_di), 32'(exp_vic_di));
        check("cpu_di", 32'(cpu_di), 32'(exp_cpu_di));

        fd2 = fd1; vd2 = vd1; cd2 = cd1; cv2 = cv1;
        fd1 = !drives;
        vd1 = ref_mem[vic_addr];
        cd1 = grant && !rq_we;
        cv1 = ref_mem[rq_addr];
        if (grant && rq_we) ref_mem[rq_addr] = rq_do;
        if (grant) rq_new = 1;
        if (!slot_cpu) begin
            if (!ba_low && req_val) begin
                ba_low = 1; left = BW;
            end else if (ba_low && !req_val) begin
                ba_low = 0; stolen = 0;
            end
        end else if (ba_low && !stolen) begin
            left--;
            if (left == 0) stolen = 1;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phi2"}, 32'(phi2), 32'(0));
        check({tag, "_cpu_rdy"}, 32'(cpu_rdy), 32'(0));
        check({tag, "_ba"}, 32'(ba), 32'(1));
        check({tag, "_aec"}, 32'(aec), 32'(1));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        check({tag, "_vic_di_valid"}, 32'(vic_di_valid), 32'(0));
        check({tag, "_cpu_di"}, 32'(cpu_di), 32'(0));
        check({tag, "_vic_di"}, 32'(vic_di), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        cpu_addr = '0; cpu_do = '0; cpu_we = 1'b0; vic_addr = '0; vic_ba_req = 1'b0;
        model_reset();
        rq_addr = 16'hE000; rq_we = 1'b0; rq_do = '0; rq_new = 0;
        req_val = 1'b0; req_left = 4;

        #12;
        check_reset_values("reset");

        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) run_cycle(1'b0);

        // Drive into VIC ownership, then reset with a stalled write pending.
        for (int i = 0; i < 40 && !stolen; i++) run_cycle(1'b1);
        check("stolen_before_reset", 32'(stolen), 32'(1));
        rq_addr = 16'hD020; rq_do = 8'h55; rq_we = 1'b1; rq_new = 0;
        run_cycle(1'b1);
        cpu_addr = rq_addr; cpu_do = rq_do; cpu_we = 1'b1;
        #1;
        check("aec_low_pre_reset", 32'(aec), 32'(0));
        #1 reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        req_left = 0;
        for (int i = 0; i < 1500; i++) run_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/c64_bus_arbiter.md
Name: c64_bus_arbiter

Overview:
- Shares one synchronous memory bus between the 6502 core and the VIC-II fetch engine.
- Generates the phi2 slot phase: VIC slot when phi2=0, CPU slot when phi2=1.
- Drives the CPU RDY input and the BA/AEC stealing sequence.
- Muxes address, write data and write enable onto the shared memory, and steers returned read data to the correct requester.

Parameters:
- ADDR_W, 16, address width of all address buses.
- DATA_W, 8, data width of all data buses.
- BA_WARN, 3, CPU slots between BA falling and AEC falling.

Ports:
- clk  in  1  system clock, two clks per phi2 period.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  CPU address bus (AB).
- cpu_do  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdy  out  1  CPU RDY; high only in a granted CPU slot.
- cpu_di  out  DATA_W  read data to CPU.
- vic_addr  in  ADDR_W  VIC fetch address.
- vic_ba_req  in  1  VIC requests the bus (badline/sprite DMA).
- vic_di  out  DATA_W  read data returned to VIC.
- vic_di_valid  out  1  one-clk pulse; vic_di is new.
- phi2  out  1  slot phase.
- ba  out  1  bus available, active-low warning.
- aec  out  1  address enable control; 0 means the VIC owns CPU slots.
- mem_addr  out  ADDR_W  shared memory address.
- mem_wdata  out  DATA_W  shared memory write data.
- mem_we  out  1  shared memory write strobe.
- mem_rdata  in  DATA_W  memory read data, valid the clk after its address.

Behaviour:
- Reset values (reset low, asynchronous):
  - phi2=0, cpu_rdy=0, ba=1, aec=1, mem_we=0, vic_di_valid=0.
  - cpu_di=0, vic_di=0, state=CPU_OWN, counter=0.
- phi2 toggles every clk after reset release; the first slot after release is a VIC slot.
- VIC slot (phi2=0): mem_addr=vic_addr, mem_we=0. Data returns next clk → vic_di registered and vic_di_valid=1 for that clk.
- CPU slot (phi2=1):
  - Owner is CPU when state is CPU_OWN or WARN; owner is VIC when state is VIC_OWN.
  - If owner=VIC: mem_addr=vic_addr, mem_we=0, cpu_rdy=0, and the data returned is also delivered to the VIC with vic_di_valid.
  - If owner=CPU: mem_addr=cpu_addr and mem_wdata=cpu_do.
  - Write: mem_we = cpu_we & cpu_rdy.
- cpu_di:
  - Equals mem_rdata in the clk following a granted CPU read slot.
  - Otherwise holds the last CPU read value; it never shows VIC data.
- Grant rules: cpu_rdy=1 in a CPU slot when state=CPU_OWN, or when state=WARN and cpu_we=1. It is 0 in every VIC slot.
- vic_ba_req is sampled only on the clk edge that ends a VIC slot. There is exactly one sample per phi2 period, so simultaneous request/release cannot occur.
- State machine:
  - CPU_OWN → WARN when the sample is 1. ba←0, counter←BA_WARN.
  - WARN:
    - Each CPU slot decrements the counter, whether it was a write grant or a read stall.
    - Counter reaching 0 at the end of a CPU slot → VIC_OWN, aec←0.
    - A sample of 0 while in WARN → CPU_OWN, ba←1, counter←0; the current CPU slot already uses the new state.
  - VIC_OWN → CPU_OWN when the sample is 0. ba←1, aec←1 before the next CPU slot.
- A CPU read stalled in WARN keeps cpu_addr stable. It is granted in the first CPU slot after returning to CPU_OWN.
- Counter width is clog2(BA_WARN+1). It never wraps; it saturates at 0.
- Reset mid-sequence:
  - Any in-flight write is dropped; mem_we falls immediately.
  - Returns to CPU_OWN with ba=1, aec=1.
- No combinational path from mem_rdata to mem_addr or mem_we.

Decomposition:
- Package c64_bus_pkg holds:
  - State enum {CPU_OWN, WARN, VIC_OWN}.
  - Slot constants SLOT_VIC=0, SLOT_CPU=1.
  - Default widths ADDR_W=16, DATA_W=8.
- No sub-module; the phase toggle, counter and state machine live in one module.

Test Plan:
- Reset release, vic_ba_req=0, CPU reads $E000 (rom=$A9) → phi2 alternates 0,1,…; cpu_rdy high only when phi2=1; cpu_di=$A9 the clk after the CPU slot; vic_di_valid pulses every VIC slot.
- CPU writes $55 to $D020 in a CPU slot → mem_we=1 for exactly that clk, mem_addr=$D020, mem_wdata=$55; no mem_we in VIC slots.
- vic_ba_req=1 while the CPU issues 3 writes → ba falls after the sample; 3 write grants; then aec=0. Next CPU slot: mem_addr=vic_addr, cpu_rdy=0, vic_di_valid=1.
- vic_ba_req=1 while the CPU reads → cpu_rdy=0 on all 3 WARN slots, then VIC_OWN. Drop the request: ba=1, aec=1; the stalled read of $0801 is granted in the next CPU slot with cpu_di=mem[$0801].
- Request asserted for one phi2 period only, then dropped inside WARN (counter=2) → ba returns to 1, aec never falls, the CPU read is granted in the following CPU slot.
- Assert reset low during VIC_OWN with a CPU write pending → mem_we=0, ba=1, aec=1, cpu_rdy=0 asynchronously; normal alternation resumes after release.
